// File: rtl/seq_mul16_if.sv
// seq_mul16_if
// Handshake and data bundle for the sequential multiplier.
//   in_valid/in_ready/a/b         : operand request channel (master -> slave)
//   out_valid/out_ready/out       : product response channel (slave -> master)
//   busy                          : slave is stepping through a multiplication
// The master modport is the requester (issue path / testbench); the slave
// modport is the multiplier itself.
interface seq_mul16_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, out, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, out, busy
   );
endinterface

// File: rtl/seq_mul16.sv
// seq_mul16
// Shift-and-add multiplier producing the low WIDTH bits of a*b. One partial
// product is folded in per cycle through a ripple-carry adder whose carry-out
// is discarded, so signed and unsigned operands give the same low bits.
// Ports:
//   clk    : system clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   bus    : seq_mul16_if slave modport (operand/product handshakes, busy)
// Parameters:
//   WIDTH      : operand/product width
//   EARLY_EXIT : 1 = leave RUN once the remaining multiplier bits are all zero
module seq_mul16 #(
   parameter int WIDTH      = 16,
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   seq_mul16_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_reg,  state_next;
   logic [WIDTH-1:0] acc_reg,    acc_next;
   logic [WIDTH-1:0] mcand_reg,  mcand_next;
   logic [WIDTH-1:0] mplier_reg, mplier_next;
   logic [CW-1:0]    count_reg,  count_next;
   logic [WIDTH-1:0] out_reg,    out_next;

   // ripple-carry adder: acc + (mplier[0] ? mcand : 0), carry-out dropped
   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] carry;

   assign addend   = mplier_reg[0] ? mcand_reg : '0;
   assign carry[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_add
         assign sum[gi] = acc_reg[gi] ^ addend[gi] ^ carry[gi];
         // the carry out of the top bit is the overflow and is not built
         if (gi < WIDTH - 1) begin : g_carry
            assign carry[gi+1] = (acc_reg[gi] & addend[gi]) |
                                 (carry[gi] & (acc_reg[gi] ^ addend[gi]));
         end
      end
   endgenerate

   logic [WIDTH-1:0] mplier_shift;
   logic             last_step;

   assign mplier_shift = mplier_reg >> 1;
   // early exit looks at the multiplier as it will be after this step, so a
   // zero multiplier still spends exactly one cycle in RUN
   assign last_step    = (count_reg == CW'(WIDTH - 1)) ||
                         (EARLY_EXIT && (mplier_shift == '0));

   always_comb begin
      state_next  = state_reg;
      acc_next    = acc_reg;
      mcand_next  = mcand_reg;
      mplier_next = mplier_reg;
      count_next  = count_reg;
      out_next    = out_reg;

      case (state_reg)
         S_IDLE: begin
            if (bus.in_valid) begin
               acc_next    = '0;
               mcand_next  = bus.a;
               mplier_next = bus.b;
               count_next  = '0;
               state_next  = S_RUN;
            end
         end
         S_RUN: begin
            acc_next    = sum;
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_shift;
            count_next  = count_reg + CW'(1);
            if (last_step) begin
               // out tracks the final accumulator so it is already valid
               // on the first DONE cycle and holds afterwards
               out_next   = sum;
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         acc_reg    <= '0;
         mcand_reg  <= '0;
         mplier_reg <= '0;
         count_reg  <= '0;
         out_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         acc_reg    <= acc_next;
         mcand_reg  <= mcand_next;
         mplier_reg <= mplier_next;
         count_reg  <= count_next;
         out_reg    <= out_next;
      end
   end

   // all handshake outputs come straight from the state register
   assign bus.in_ready  = (state_reg == S_IDLE);
   assign bus.busy      = (state_reg == S_RUN);
   assign bus.out_valid = (state_reg == S_DONE);
   assign bus.out       = out_reg;

endmodule
